imem_boot_ctrl: RTL and testbench

Controller that owns the single-port, word-addressed instruction memory and sequences it between two users: a program-load stream (boot/debug loader) and the CPU fetch path. After reset it holds the CPU stalled and lets the loader write the program word by word. On the last word it releases the CPU, which then fetches through the same memory port. It sits between the fetch stage (PC / instruction) and the instruction memory array.

---
 rtl/imem_boot_ctrl.sv | 131 +++++++++++++
 tb/tb_imem_boot_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - instruction memory owner: program loader then CPU fetch; optional IMEM_CHECKSUM_EN
module imem_boot_ctrl #(
    parameter int IMEM_WIDTH = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [IMEM_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    input  logic [31:0]           cpu_pc,
    output logic [IMEM_WIDTH-1:0] cpu_instr,
    output logic                  cpu_stall,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [IMEM_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [IMEM_WIDTH-1:0] mem_rdata,
    output logic                  load_done,
    output logic                  load_err,
`ifdef IMEM_CHECKSUM_EN
    output logic [IMEM_WIDTH-1:0] ld_csum,
`endif
    output logic [ADDR_W:0]       word_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ERR} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(IMEM_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              load_err_q, load_err_d;
    logic              accept;
    logic [ADDR_W-1:0] wr_ptr;
    logic              unused_pc_bits;

    // The write pointer is always the low bits of the word count.
    assign wr_ptr         = word_cnt_q[ADDR_W-1:0];
    assign unused_pc_bits = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        load_err_d = load_err_q;
        accept     = 1'b0;
        cpu_stall  = 1'b1;
        ld_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = wr_ptr;
        mem_wdata  = ld_data;
        cpu_instr  = '0;
        load_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    state_d    = S_LOAD;
                    word_cnt_d = '0;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_start) begin
                    word_cnt_d = '0;
                end else if (ld_valid) begin
                    if (word_cnt_q == FULL_CNT) begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        accept     = 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (ld_last) state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cpu_stall = 1'b0;
                load_done = 1'b1;
                mem_addr  = cpu_pc[ADDR_W+1:2];
                cpu_instr = mem_rdata;
                if (ld_start) begin
                    state_d    = S_LOAD;
                    word_cnt_d = '0;
                end
            end
            default: begin
                if (ld_start) begin
                    state_d    = S_LOAD;
                    word_cnt_d = '0;
                    load_err_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            load_err_q <= load_err_d;
        end
    end

    assign word_cnt = word_cnt_q;
    assign load_err = load_err_q;

`ifdef IMEM_CHECKSUM_EN
    logic [IMEM_WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (ld_start)    csum_d = '0;
        else if (accept) csum_d = csum_q + ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end

    assign ld_csum = csum_q;
`endif

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - directed self-checking bench for imem_boot_ctrl
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start, ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        load_done, load_err;
    logic [8:0]  word_cnt;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0] ld_csum;
`endif

    logic [31:0] mem [0:255];
    logic [31:0] prog [0:13];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imem_boot_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .cpu_pc    (cpu_pc),
        .cpu_instr (cpu_instr),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .load_done (load_done),
        .load_err  (load_err),
`ifdef IMEM_CHECKSUM_EN
        .ld_csum   (ld_csum),
`endif
        .word_cnt  (word_cnt)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        prog[0]  = 32'h00008020; prog[1]  = 32'h20100001; prog[2]  = 32'h20110005;
        prog[3]  = 32'h02118020; prog[4]  = 32'h2231FFFF; prog[5]  = 32'h1620FFFD;
        prog[6]  = 32'hAC100000; prog[7]  = 32'h8C080000; prog[8]  = 32'h01084020;
        prog[9]  = 32'h3C0A1234; prog[10] = 32'h354A5678; prog[11] = 32'h014B6025;
        prog[12] = 32'h08000000; prog[13] = 32'hAC120000;

        rst = 1'b1; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = 0; cpu_pc = 0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_stall", 32'(cpu_stall), 32'd1);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_instr", cpu_instr, 32'h0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);

        // Test 1: 14-word program load
        ld_start = 1; tick(); ld_start = 0;
        settle();
        check("load_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 14; i++) begin
            ld_valid = 1; ld_data = prog[i]; ld_last = (i == 13);
            settle();
            check($sformatf("ld_we_%0d", i), 32'(mem_we), 32'd1);
            check($sformatf("ld_addr_%0d", i), 32'(mem_addr), 32'(i));
            tick();
        end
        ld_valid = 0; ld_last = 0;
        settle();
        check("run_done", 32'(load_done), 32'd1);
        check("run_stall", 32'(cpu_stall), 32'd0);
        check("run_cnt", 32'(word_cnt), 32'd14);
        check("run_we", 32'(mem_we), 32'd0);
        check("mem_word13", mem[13], 32'hAC120000);

        // Test 2: fetch addressing
        cpu_pc = 32'h14; settle();
        check("pc14_addr", 32'(mem_addr), 32'd5);
        check("pc14_instr", cpu_instr, 32'h1620FFFD);
        cpu_pc = 32'h17; settle();
        check("pc17_addr", 32'(mem_addr), 32'd5);
        cpu_pc = 32'h400; settle();
        check("pc400_addr", 32'(mem_addr), 32'd0);
        check("pc400_instr", cpu_instr, 32'h00008020);

        // Test 5b: reload from RUN stalls from the next cycle
        ld_start = 1; settle();
        check("reload_stall_same", 32'(cpu_stall), 32'd0);
        tick(); ld_start = 0; settle();
        check("reload_stall_next", 32'(cpu_stall), 32'd1);
        check("reload_cnt", 32'(word_cnt), 32'd0);

        // Test 5a: restart beats a simultaneous word at wr_ptr=5
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1; ld_data = 32'h100 + i; tick();
        end
        ld_start = 1; ld_valid = 1; ld_data = 32'hDEAD0005; settle();
        check("restart_we", 32'(mem_we), 32'd0);
        tick(); ld_start = 0; ld_valid = 0; settle();
        check("restart_cnt", 32'(word_cnt), 32'd0);
        check("restart_ptr", 32'(mem_addr), 32'd0);
        check("restart_nowrite", mem[5], 32'h1620FFFD);

        // Test 4: reset mid-load keeps already-written words
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_data = 32'hA0 + i; tick();
        end
        ld_valid = 0; rst = 1; tick(); rst = 0; settle();
        check("rstld_cnt", 32'(word_cnt), 32'd0);
        check("rstld_stall", 32'(cpu_stall), 32'd1);
        check("rstld_instr", cpu_instr, 32'h0);
        check("rstld_ready", 32'(ld_ready), 32'd0);
        for (int i = 0; i < 3; i++) check($sformatf("rstld_mem%0d", i), mem[i], 32'hA0 + i);

        // Test 3: overflow into ERR
        ld_start = 1; tick(); ld_start = 0;
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1; ld_data = 32'h5000 + i; settle();
            if (i == 255) begin
                check("full_we255", 32'(mem_we), 32'd1);
                check("full_addr255", 32'(mem_addr), 32'd255);
            end
            tick();
        end
        ld_data = 32'hBADBAD00; settle();
        check("ovf_we", 32'(mem_we), 32'd0);
        tick(); ld_valid = 0; settle();
        check("err_flag", 32'(load_err), 32'd1);
        check("err_stall", 32'(cpu_stall), 32'd1);
        check("err_cnt", 32'(word_cnt), 32'd256);
        check("err_ready", 32'(ld_ready), 32'd0);
        check("err_instr", cpu_instr, 32'h0);
        check("err_mem0", mem[0], 32'h5000);
        tick();
        check("err_hold", 32'(load_err), 32'd1);
        ld_start = 1; tick(); ld_start = 0; settle();
        check("err_clr", 32'(load_err), 32'd0);
        check("err_reload", 32'(ld_ready), 32'd1);
        check("err_reload_cnt", 32'(word_cnt), 32'd0);

`ifdef IMEM_CHECKSUM_EN
        // Test 6: checksum wraps modulo 2^32
        ld_valid = 1; ld_data = 32'hFFFFFFFF; ld_last = 0; tick();
        ld_data = 32'h00000002; ld_last = 1; tick();
        ld_valid = 0; ld_last = 0; settle();
        check("csum_run_done", 32'(load_done), 32'd1);
        check("csum_val", ld_csum, 32'h00000001);
        ld_start = 1; tick(); ld_start = 0; settle();
        check("csum_clr", ld_csum, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
